hazard_stall_ctrl: RTL
======================

# hazard_stall_ctrl

Pipeline hazard and stall controller for the 5-stage MIPS datapath. It drives the write-enable, flush and bubble controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three conditions:
- load-use hazards;
- taken-branch flushes;
- variable-latency data-memory waits, with a timeout that raises a sticky fault.

It also keeps saturating performance counters for stalls and flushes.

## Interface
Parameters
- MAX_WAIT, default 255: last WaitCnt value still tolerated before a memory wait becomes a fault. Legal range 1..255; WaitCnt is 8 bits.

Ports
- Clk  in  1  system clock, rising edge
- Rst  in  1  reset; one clock; reset is synchronous and active-high
- IDEX_MemRead  in  1  instruction in EX is a load
- IDEX_Rt  in  5  load destination register in EX
- IFID_Rs  in  5  source register of the instruction in ID
- IFID_Rt  in  5  second source register of the instruction in ID
- IFID_UsesRt  in  1  instruction in ID reads Rt
- BranchTaken  in  1  branch resolved taken in ID this cycle
- Mem_req  in  1  instruction in MEM accesses data memory
- Mem_ready  in  1  data memory completes the access this cycle
- PCWrite  out  1  PC load enable
- IFID_Write  out  1  IF/ID load enable
- IFID_Flush  out  1  clear IF/ID to a NOP
- IDEX_Write  out  1  ID/EX load enable
- IDEX_Bubble  out  1  load ID/EX with zeroed control signals
- EXMEM_Write  out  1  EX/MEM load enable
- MEMWB_Bubble  out  1  load MEM/WB with RegWrite=0 and MemToReg=0
- MemFault  out  1  sticky memory-timeout fault
- StallCycles  out  16  cycles with any stall, saturating
- LoadUseCount  out  16  load-use stall cycles, saturating
- FlushCount  out  16  branch flush cycles, saturating

## Operation
- **FSM states:** RUN, MEMWAIT, FAULT. Internal WaitCnt is 8 bits.
- **MemStall** = Mem_req & ~Mem_ready.
- **LoadUse** = IDEX_MemRead & (IDEX_Rt != 0) & ((IDEX_Rt == IFID_Rs) | (IFID_UsesRt & (IDEX_Rt == IFID_Rt))).
- **Priority:** FAULT > MemStall > LoadUse > BranchTaken > normal.
- **Normal:** all *_Write = 1, all flush and bubble outputs = 0.
- **MemStall (RUN or MEMWAIT):**
  - PCWrite = IFID_Write = IDEX_Write = EXMEM_Write = 0.
  - MEMWB_Bubble = 1.
  - IFID_Flush = IDEX_Bubble = 0.
  - BranchTaken and LoadUse are ignored.
- **LoadUse:**
  - PCWrite = IFID_Write = 0, IDEX_Write = 1, IDEX_Bubble = 1, EXMEM_Write = 1.
  - BranchTaken is ignored; the branch re-evaluates next cycle.
- **BranchTaken:** IFID_Flush = 1, all writes = 1.
- **FAULT:**
  - All *_Write = 0.
  - IFID_Flush = IDEX_Bubble = MEMWB_Bubble = 1.
  - MemFault = 1.
- **State transitions:**
  - RUN: MemStall → MEMWAIT and WaitCnt ← 1; otherwise stay, WaitCnt ← 0.
  - MEMWAIT: ~MemStall → RUN and WaitCnt ← 0. MemStall with WaitCnt == MAX_WAIT → FAULT. Otherwise WaitCnt ← WaitCnt + 1.
  - FAULT: held until Rst.
- **Counters:**
  - StallCycles increments in each RUN/MEMWAIT cycle with MemStall or LoadUse.
  - LoadUseCount increments only on LoadUse stall cycles that are not overridden by MemStall.
  - FlushCount increments on each cycle that IFID_Flush is asserted because of a branch.
  - All counters saturate at 16'hFFFF and never wrap.
  - All counters freeze in FAULT.

## Timing
- Control outputs are combinational from the current state and current inputs; they take effect in the same cycle.
- State, WaitCnt, MemFault and the counters update on posedge Clk.
- **Rst high at an edge:** next state RUN, WaitCnt = 0, MemFault = 0, all counters = 0. This holds from any state, including mid-MEMWAIT and FAULT.
- **While Rst = 1:**
  - PCWrite = IFID_Write = IDEX_Write = EXMEM_Write = 0.
  - IFID_Flush = IDEX_Bubble = MEMWB_Bubble = 1.
  - MemFault = 0.
- **Load-use latency:** exactly one stall cycle per load-use pair. On the next cycle the load is in MEM and the hazard clears.
- **Memory wait:** Mem_ready = 1 releases the stall in the same cycle, and normal enables apply in that cycle.
- **Fault latency:** a wait still stalled after MAX_WAIT+1 consecutive stall cycles enters FAULT on the next cycle.
- Mem_ready without Mem_req has no effect.

## Test plan
- **Load-use:** lw writes $t0 (IDEX_Rt = 8, IDEX_MemRead = 1) with IFID_Rs = 8.
  - Expect one cycle with PCWrite = 0, IFID_Write = 0, IDEX_Bubble = 1; LoadUseCount = 1, StallCycles = 1.
  - Repeat with IDEX_Rt = 0: expect no stall.
- **Branch flush:** BranchTaken = 1 for one cycle with no hazard.
  - Expect IFID_Flush = 1 and PCWrite = 1; FlushCount = 1.
  - Repeat with LoadUse also true: expect IFID_Flush = 0 and FlushCount unchanged.
- **Memory wait:** Mem_req = 1, Mem_ready low for 3 cycles and then high.
  - Expect 3 cycles with all writes 0 and MEMWB_Bubble = 1, then release in the Mem_ready cycle; StallCycles = 3.
- **Stall overlap:** MemStall and LoadUse true together.
  - Expect memory-stall outputs (IDEX_Bubble = 0); LoadUseCount unchanged.
- **Timeout:** MAX_WAIT = 4, Mem_ready held low.
  - Expect 5 stall cycles, then FAULT with MemFault = 1 and all writes 0.
  - Counters freeze; Rst returns to RUN with MemFault = 0 and counters = 0.
- **Saturation and reset:**
  - Preload-equivalent run of 65 540 load-use cycles: expect StallCycles = LoadUseCount = 16'hFFFF.
  - Assert Rst mid-MEMWAIT: expect the reset output values during Rst and RUN next cycle.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
// Stall and flush control for the five-stage MIPS pipeline. It handles load-use
// hazards, taken-branch flushes and variable-latency data memory waits. A memory
// wait that runs too long ends in a sticky fault. Saturating counters record
// stall and flush activity.

module hazard_stall_ctrl #(
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        IDEX_MemRead,
   input  logic [4:0]  IDEX_Rt,
   input  logic [4:0]  IFID_Rs,
   input  logic [4:0]  IFID_Rt,
   input  logic        IFID_UsesRt,
   input  logic        BranchTaken,
   input  logic        Mem_req,
   input  logic        Mem_ready,
   output logic        PCWrite,
   output logic        IFID_Write,
   output logic        IFID_Flush,
   output logic        IDEX_Write,
   output logic        IDEX_Bubble,
   output logic        EXMEM_Write,
   output logic        MEMWB_Bubble,
   output logic        MemFault,
   output logic [15:0] StallCycles,
   output logic [15:0] LoadUseCount,
   output logic [15:0] FlushCount
);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MEMWAIT = 2'd1,
      FAULT   = 2'd2
   } state_t;

   localparam logic [7:0] MaxWaitCnt = 8'(MAX_WAIT);

   state_t      r_state;
   logic [7:0]  r_waitCnt;
   logic        r_memFault;
   logic [15:0] r_stallCycles;
   logic [15:0] r_loadUseCount;
   logic [15:0] r_flushCount;

   logic w_memStall;
   logic w_loadUse;
   logic w_branchFlush;
   logic w_inFault;

   // Hazard detection. A load into $zero never creates a dependency.
   always_comb begin
      w_memStall    = Mem_req & ~Mem_ready;
      w_loadUse     = IDEX_MemRead & (IDEX_Rt != 5'd0) &
                      ((IDEX_Rt == IFID_Rs) | (IFID_UsesRt & (IDEX_Rt == IFID_Rt)));
      w_branchFlush = BranchTaken & ~w_memStall & ~w_loadUse;
      w_inFault     = (r_state == FAULT);
   end

   // Pipeline register enables, priority-encoded. Reset and fault both freeze
   // every stage and push NOPs into the pipeline.
   always_comb begin
      PCWrite      = 1'b1;
      IFID_Write   = 1'b1;
      IFID_Flush   = 1'b0;
      IDEX_Write   = 1'b1;
      IDEX_Bubble  = 1'b0;
      EXMEM_Write  = 1'b1;
      MEMWB_Bubble = 1'b0;
      if (Rst || w_inFault) begin
         PCWrite      = 1'b0;
         IFID_Write   = 1'b0;
         IDEX_Write   = 1'b0;
         EXMEM_Write  = 1'b0;
         IFID_Flush   = 1'b1;
         IDEX_Bubble  = 1'b1;
         MEMWB_Bubble = 1'b1;
      end else if (w_memStall) begin
         PCWrite      = 1'b0;
         IFID_Write   = 1'b0;
         IDEX_Write   = 1'b0;
         EXMEM_Write  = 1'b0;
         MEMWB_Bubble = 1'b1;
      end else if (w_loadUse) begin
         PCWrite      = 1'b0;
         IFID_Write   = 1'b0;
         IDEX_Bubble  = 1'b1;
      end else if (BranchTaken) begin
         IFID_Flush   = 1'b1;
      end
   end

   // The fault flag reads as clear while reset is held, even if FAULT is current.
   always_comb begin
      MemFault     = r_memFault & ~Rst;
      StallCycles  = r_stallCycles;
      LoadUseCount = r_loadUseCount;
      FlushCount   = r_flushCount;
   end

   // Memory-wait FSM with timeout and the saturating counters. Nothing
   // advances once FAULT is reached; only reset leaves it.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state        <= RUN;
         r_waitCnt      <= 8'd0;
         r_memFault     <= 1'b0;
         r_stallCycles  <= 16'd0;
         r_loadUseCount <= 16'd0;
         r_flushCount   <= 16'd0;
      end else begin
         case (r_state)
            RUN: begin
               if (w_memStall) begin
                  r_state   <= MEMWAIT;
                  r_waitCnt <= 8'd1;
               end else begin
                  r_waitCnt <= 8'd0;
               end
            end
            MEMWAIT: begin
               if (!w_memStall) begin
                  r_state   <= RUN;
                  r_waitCnt <= 8'd0;
               end else if (r_waitCnt == MaxWaitCnt) begin
                  r_state    <= FAULT;
                  r_memFault <= 1'b1;
               end else begin
                  r_waitCnt <= r_waitCnt + 8'd1;
               end
            end
            FAULT: begin
               r_state <= FAULT;
            end
            default: begin
               r_state   <= RUN;
               r_waitCnt <= 8'd0;
            end
         endcase

         if (!w_inFault) begin
            if ((w_memStall || w_loadUse) && (r_stallCycles != 16'hFFFF))
               r_stallCycles <= r_stallCycles + 16'd1;
            if (w_loadUse && !w_memStall && (r_loadUseCount != 16'hFFFF))
               r_loadUseCount <= r_loadUseCount + 16'd1;
            if (w_branchFlush && (r_flushCount != 16'hFFFF))
               r_flushCount <= r_flushCount + 16'd1;
         end
      end
   end

endmodule
